// File: rtl/instr_fetch_mem.sv
// ============================================================================
// Module      : instr_fetch_mem
// Description : Byte-preloaded instruction memory with a one-deep, 1-cycle
//               latency big-endian word fetch port. Optional misalignment
//               check enabled by macro INSTR_FETCH_MEM_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_mem #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic                      flush,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [8*WORD_BYTES-1:0]   rsp_data,
  output logic                      rsp_err,
  input  logic                      ld_en,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [7:0]                ld_byte
);

  localparam int unsigned DW    = 8 * WORD_BYTES;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Byte index of (a + off) with wrap-around at DEPTH.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_W-1:0] a,
                                                input int unsigned       off);
    int unsigned s;
    s = (32'(a) + off) % DEPTH;
    return s[IDX_W-1:0];
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [DW-1:0] w_word;
  logic          w_accept;

  state_t        state_q, state_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  // Preload port; memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[wrap_idx(ld_addr, 0)] <= ld_byte;
    end
  end

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_byte
    assign w_word[DW-1-8*i -: 8] = mem_q[wrap_idx(req_addr, i)];
  end

  assign req_ready = !reset && ((state_q == EMPTY) || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;

`ifdef INSTR_FETCH_MEM_ALIGN_CHK_EN
  logic rsp_err_q, rsp_err_d;
  logic w_misaligned;

  assign w_misaligned = (32'(req_addr) % WORD_BYTES) != 0;
  assign rsp_err      = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
`ifdef INSTR_FETCH_MEM_ALIGN_CHK_EN
    rsp_err_d  = rsp_err_q;
`endif
    if (w_accept) begin
      state_d = FULL;
`ifdef INSTR_FETCH_MEM_ALIGN_CHK_EN
      rsp_err_d  = w_misaligned;
      rsp_data_d = w_misaligned ? '0 : w_word;
`else
      rsp_data_d = w_word;
`endif
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
    // Flush wins over a same-cycle accept.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
`ifdef INSTR_FETCH_MEM_ALIGN_CHK_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
`ifdef INSTR_FETCH_MEM_ALIGN_CHK_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
// ============================================================================
// Module      : tb_instr_fetch_mem
// Description : Directed self-checking bench for instr_fetch_mem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_mem;

  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DEPTH      = 512;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DW         = 8 * WORD_BYTES;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              flush = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [7:0]        ld_byte = '0;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_mem #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .WORD_BYTES(WORD_BYTES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_byte  (ld_byte)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned a, input logic [7:0] b);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_byte = b;
    tick();
    ld_en   = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check_eq("rst_valid", 64'(rsp_valid), 64'h0);
    check_eq("rst_data",  64'(rsp_data),  64'h0);
    check_eq("rst_err",   64'(rsp_err),   64'h0);
    check_eq("rst_ready", 64'(req_ready), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("idle_ready", 64'(req_ready), 64'h1);

    for (int i = 0; i < 8; i++) load(i, 8'(8'h11 * (i + 1)));

    // Back-to-back fetch, one word per cycle
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 9'd0;
    tick();
    check_eq("b2b_v0", 64'(rsp_valid), 64'h1);
    check_eq("b2b_d0", 64'(rsp_data),  64'h11223344);
    req_addr = 9'd4;
    tick();
    check_eq("b2b_v1", 64'(rsp_valid), 64'h1);
    check_eq("b2b_d1", 64'(rsp_data),  64'h55667788);
    req_valid = 1'b0;
    tick();
    check_eq("b2b_drain", 64'(rsp_valid), 64'h0);

    // Backpressure: response held stable, second request waits
    req_valid = 1'b1;
    req_addr  = 9'd0;
    rsp_ready = 1'b0;
    tick();
    req_addr = 9'd4;
    #1;
    check_eq("bp_ready0", 64'(req_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", 64'(rsp_valid), 64'h1);
      check_eq("bp_data",  64'(rsp_data),  64'h11223344);
      check_eq("bp_ready", 64'(req_ready), 64'h0);
      tick();
    end
    check_eq("bp_hold",   64'(rsp_data),  64'h11223344);
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_ready1", 64'(req_ready), 64'h1);
    tick();
    check_eq("bp_next",   64'(rsp_data),  64'h55667788);
    check_eq("bp_nextv",  64'(rsp_valid), 64'h1);
    req_valid = 1'b0;
    tick();
    check_eq("bp_drain",  64'(rsp_valid), 64'h0);

    // Read-before-write on a same-cycle preload
    req_valid = 1'b1;
    req_addr  = 9'd0;
    ld_en     = 1'b1;
    ld_addr   = 9'd1;
    ld_byte   = 8'hFF;
    tick();
    ld_en = 1'b0;
    check_eq("rbw_old", 64'(rsp_data), 64'h11223344);
    tick();
    check_eq("rbw_new", 64'(rsp_data), 64'h11FF3344);
    req_valid = 1'b0;
    tick();

    // Flush overrides a same-cycle accept
    req_valid = 1'b1;
    req_addr  = 9'd4;
    flush     = 1'b1;
    #1;
    check_eq("flush_ready", 64'(req_ready), 64'h1);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check_eq("flush_valid", 64'(rsp_valid), 64'h0);

    // Asynchronous reset while FULL
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check_eq("pre_rst_valid", 64'(rsp_valid), 64'h1);
    check_eq("pre_rst_data",  64'(rsp_data),  64'h55667788);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", 64'(rsp_valid), 64'h0);
    check_eq("arst_data",  64'(rsp_data),  64'h0);
    check_eq("arst_ready", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_eq("post_rst_valid", 64'(rsp_valid), 64'h0);

    // Wrap-around fetch at the top of memory
    load(510, 8'hAA);
    load(511, 8'hBB);
    load(0,   8'hCC);
    load(1,   8'hDD);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 9'd510;
    tick();
    check_eq("wrap_valid", 64'(rsp_valid), 64'h1);
`ifdef INSTR_FETCH_MEM_ALIGN_CHK_EN
    check_eq("wrap_err",  64'(rsp_err),  64'h1);
    check_eq("wrap_data", 64'(rsp_data), 64'h0);
`else
    check_eq("wrap_err",  64'(rsp_err),  64'h0);
    check_eq("wrap_data", 64'(rsp_data), 64'hAABBCCDD);
`endif
    // Aligned fetch after reset: memory contents preserved
    req_addr = 9'd4;
    tick();
    check_eq("kept_err",  64'(rsp_err),  64'h0);
    check_eq("kept_data", 64'(rsp_data), 64'h55667788);
    req_valid = 1'b0;
    tick();
    check_eq("end_valid", 64'(rsp_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
